// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and debounces the pad lines,
// deframes 11-bit frames and hands scan-code bytes over a valid/ready register.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clkSync1_q, clkSync2_q, dataSync1_q, dataSync2_q;
    logic          clkFilt_q, dataFilt_q, clkFiltDly_q;
    logic [7:0]    clkCnt_q, dataCnt_q;
    state_t        state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rxData_q, rxData_d;
    logic          rxValid_q, rxValid_d;
    logic          parityErr_q, parityErr_d;
    logic          frameErr_q, frameErr_d;
    logic          overrun_q, overrun_d;
    logic          fallStrobe;
    logic          frameOk;

    // Bus idles high, so synchronizers and filters reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync1_q   <= 1'b1;
            clkSync2_q   <= 1'b1;
            dataSync1_q  <= 1'b1;
            dataSync2_q  <= 1'b1;
            clkFilt_q    <= 1'b1;
            dataFilt_q   <= 1'b1;
            clkFiltDly_q <= 1'b1;
            clkCnt_q     <= '0;
            dataCnt_q    <= '0;
        end else begin
            clkSync1_q   <= ps2_clk_in;
            clkSync2_q   <= clkSync1_q;
            dataSync1_q  <= ps2_data_in;
            dataSync2_q  <= dataSync1_q;
            clkFiltDly_q <= clkFilt_q;
            if (clkSync2_q == clkFilt_q) begin
                clkCnt_q <= '0;
            end else if (clkCnt_q == 8'(FILTER_LEN - 1)) begin
                clkFilt_q <= clkSync2_q;
                clkCnt_q  <= '0;
            end else begin
                clkCnt_q <= clkCnt_q + 8'd1;
            end
            if (dataSync2_q == dataFilt_q) begin
                dataCnt_q <= '0;
            end else if (dataCnt_q == 8'(FILTER_LEN - 1)) begin
                dataFilt_q <= dataSync2_q;
                dataCnt_q  <= '0;
            end else begin
                dataCnt_q <= dataCnt_q + 8'd1;
            end
        end
    end

    assign fallStrobe = clkFiltDly_q & ~clkFilt_q;

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = '0;
        rxData_d    = rxData_q;
        rxValid_d   = rxValid_q & ~rx_ready;
        parityErr_d = 1'b0;
        frameErr_d  = 1'b0;
        overrun_d   = 1'b0;
        frameOk     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fallStrobe) begin
                    if (!dataFilt_q) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fallStrobe) begin
                    shift_d  = {dataFilt_q, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fallStrobe) begin
                    parity_d = dataFilt_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fallStrobe) begin
                    state_d = IDLE;
                    if (!dataFilt_q)                 frameErr_d  = 1'b1;
                    else if (!(^{shift_q, parity_q})) parityErr_d = 1'b1;
                    else                             frameOk     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled clock mid-frame abandons the partial byte.
        if (state_q != IDLE && !fallStrobe) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frameErr_d = 1'b1;
                state_d    = IDLE;
                shift_d    = '0;
                bitCnt_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (frameOk) begin
            if (rxValid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rxData_d  = shift_q;
                rxValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            parityErr_q <= parityErr_d;
            frameErr_q  <= frameErr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames from a bit-level task and
// compares accepted bytes against a scoreboard queue.
module tb_ps2_rx;

   localparam int FILT = 4;
   localparam int TMO  = 200;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic       rxReady = 1'b0;
   logic [7:0] rxData;
   logic       rxValid, parityErr, frameErr, overrunPulse;

   int vectors = 0;
   int miscompares = 0;
   int cycleNum = 0;
   int lastFall = 0;
   int frameErrCycle = 0;
   int parityCnt = 0, frameCnt = 0, overrunCnt = 0, validRise = 0, validCycles = 0;
   int p0, f0, o0, r0, c0;
   logic prevValid = 1'b0;
   logic [7:0] expQ[$];

   ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk),
      .rst_n(rstN),
      .ps2_clk_in(ps2Clk),
      .ps2_data_in(ps2Data),
      .rx_data(rxData),
      .rx_valid(rxValid),
      .rx_ready(rxReady),
      .parity_err(parityErr),
      .frame_err(frameErr),
      .overrun(overrunPulse)
   );

   // 10 ns system clock; cycleNum numbers the rising edges.
   always #5 clk = ~clk;
   always @(posedge clk) cycleNum <= cycleNum + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives frame bits firstBit..lastBit; data changes while the PS/2 clock is high.
   task automatic applyStimulus(input logic [7:0] d, input logic flipPar, input logic stopBit,
                                input int firstBit, input int lastBit, input bit glitch);
      logic [10:0] frame;
      frame = {stopBit, (~^d) ^ flipPar, d, 1'b0};
      for (int i = firstBit; i <= lastBit; i++) begin
         ps2Data = frame[i];
         if (glitch) begin
            waitCycles(5);
            ps2Clk = 1'b0;
            waitCycles(2);
            ps2Clk = 1'b1;
            waitCycles(HALF - 7);
         end else begin
            waitCycles(HALF);
         end
         ps2Clk = 1'b0;
         lastFall = cycleNum;
         if (glitch) begin
            waitCycles(8);
            ps2Clk = 1'b1;
            waitCycles(2);
            ps2Clk = 1'b0;
            waitCycles(HALF - 10);
         end else begin
            waitCycles(HALF);
         end
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
   endtask

   task automatic snap();
      p0 = parityCnt; f0 = frameCnt; o0 = overrunCnt; r0 = validRise; c0 = validCycles;
   endtask

   // Monitor: counts pulses and pops the scoreboard on every accepted byte.
   initial begin
      forever begin
         @(negedge clk);
         if (parityErr) parityCnt++;
         if (frameErr) begin
            frameCnt++;
            frameErrCycle = cycleNum;
         end
         if (overrunPulse) overrunCnt++;
         if (rxValid) validCycles++;
         if (rxValid && !prevValid) validRise++;
         if (rxValid && rxReady) begin
            if (expQ.size() == 0) checkOutput("unexpectedByte", {24'd0, rxData}, 32'hFFFF_FFFF);
            else checkOutput("rxData", {24'd0, rxData}, {24'd0, expQ.pop_front()});
         end
         prevValid = rxValid;
      end
   end

   initial begin
      waitCycles(3);
      checkOutput("rstValid", rxValid, 0);
      checkOutput("rstData", rxData, 0);
      checkOutput("rstErrs", {parityErr, frameErr, overrunPulse}, 0);
      rstN = 1'b1;
      waitCycles(5);

      $display("[TB] frame 0x1C, ready high");
      rxReady = 1'b1;
      snap();
      expQ.push_back(8'h1C);
      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("okValidCycles", validCycles - c0, 1);
      checkOutput("okErrs", (parityCnt - p0) + (frameCnt - f0) + (overrunCnt - o0), 0);

      $display("[TB] 0xF0 then 0x1C, ready low");
      rxReady = 1'b0;
      snap();
      expQ.push_back(8'hF0);
      applyStimulus(8'hF0, 1'b0, 1'b1, 0, 10, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("ovrCount", overrunCnt - o0, 1);
      checkOutput("ovrValid", rxValid, 1);
      checkOutput("ovrData", rxData, 8'hF0);
      checkOutput("ovrNoOtherErr", (parityCnt - p0) + (frameCnt - f0), 0);
      rxReady = 1'b1;
      waitCycles(2);
      checkOutput("ovrCleared", rxValid, 0);
      checkOutput("ovrDataHeld", rxData, 8'hF0);

      $display("[TB] parity error");
      snap();
      applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("parCount", parityCnt - p0, 1);
      checkOutput("parFrameErr", frameCnt - f0, 0);
      checkOutput("parValid", validRise - r0, 0);

      $display("[TB] stop bit error");
      snap();
      applyStimulus(8'h1C, 1'b0, 1'b0, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("stopFrameErr", frameCnt - f0, 1);
      checkOutput("stopParErr", parityCnt - p0, 0);
      checkOutput("stopValid", validRise - r0, 0);

      $display("[TB] timeout after 4 data bits");
      snap();
      applyStimulus(8'h00, 1'b0, 1'b1, 0, 4, 1'b0);
      for (int i = 0; i < FILT + TMO + 60 && frameCnt == f0; i++) waitCycles(1);
      checkOutput("tmoErr", frameCnt - f0, 1);
      checkOutput("tmoLatency", frameErrCycle - lastFall, FILT + TMO + 3);
      waitCycles(3);
      checkOutput("tmoSinglePulse", frameCnt - f0, 1);
      snap();
      expQ.push_back(8'hF0);
      applyStimulus(8'hF0, 1'b0, 1'b1, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("tmoNextValid", validRise - r0, 1);
      checkOutput("tmoNextErrs", (parityCnt - p0) + (frameCnt - f0), 0);

      $display("[TB] glitches on ps2 clock");
      snap();
      expQ.push_back(8'h1C);
      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 10, 1'b1);
      waitCycles(FILT + 10);
      checkOutput("glitchValid", validRise - r0, 1);
      checkOutput("glitchErrs", (parityCnt - p0) + (frameCnt - f0), 0);

      $display("[TB] reset mid-frame");
      snap();
      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 7, 1'b0);
      rstN = 1'b0;
      waitCycles(3);
      checkOutput("midRstOutputs", {rxValid, parityErr, frameErr, overrunPulse, rxData}, 0);
      rstN = 1'b1;
      applyStimulus(8'h1C, 1'b0, 1'b1, 8, 10, 1'b0);
      waitCycles(FILT + TMO + 60);
      checkOutput("tailFrameErrAtMostOne", (frameCnt - f0) <= 1, 1);
      checkOutput("tailNoValid", validRise - r0, 0);
      checkOutput("tailOtherErrs", (parityCnt - p0) + (overrunCnt - o0), 0);
      snap();
      expQ.push_back(8'h1C);
      applyStimulus(8'h1C, 1'b0, 1'b1, 0, 10, 1'b0);
      waitCycles(FILT + 10);
      checkOutput("postRstValid", validRise - r0, 1);
      checkOutput("postRstErrs", (parityCnt - p0) + (frameCnt - f0), 0);

      checkOutput("sbEmpty", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
